fire_scheduler: RTL

- Drives the `fire` selector of a generated sync-model circuit. Each stateful element in that circuit has a capture flop enabled by `fire == index`.
- Replaces the unbound `fire` register with a deterministic or hint-guided scheduler. Only one transition commits per step, with a settle window between commits.
- Sits directly upstream of the circuit: it consumes the per-signal excitation vector (element `_precap` differs from its Q) and produces `fire`.

---
 rtl/fire_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fire_scheduler.sv
// Commit scheduler for a generated sync-model circuit: picks one excited transition per step,
// presents its index on `fire` for one cycle, then holds off for a settle window.
module fire_scheduler #(
    parameter int unsigned N             = 8,
    parameter int unsigned W             = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned QUIET_LIMIT   = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det,
    input  logic [N-1:0]     excited,
    input  logic [W-1:0]     choice,
    output logic [W-1:0]     fire,
    output logic             fire_valid,
    output logic             quiescent,
    output logic [CNT_W-1:0] fire_count
);

    localparam int unsigned QW = 8;
    localparam int unsigned SW = 4;

    localparam logic [W-1:0]     IDLE        = W'(N);
    localparam logic [W-1:0]     LAST        = W'(N - 1);
    localparam logic [QW-1:0]    QLIM        = QW'(QUIET_LIMIT);
    localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        FIRE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     fire_q, fire_d;
    logic             fire_valid_q, fire_valid_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic             quiescent_q, quiescent_d;
    logic [CNT_W-1:0] fire_count_q, fire_count_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;

    logic [2*N-1:0]   rot;
    logic             search_hit;
    logic [W:0]       search_sum;
    logic [W-1:0]     search_idx;
    logic             hint_hit;
    logic             pick_hit;
    logic [W-1:0]     pick;

    // Round-robin search: rotate excited so bit 0 lines up with ptr, then take the first set bit.
    always_comb begin
        rot        = {excited, excited} >> ptr_q;
        search_hit = 1'b0;
        search_sum = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!search_hit && rot[j]) begin
                search_hit = 1'b1;
                search_sum = {1'b0, ptr_q} + (W+1)'(j);
            end
        end
        if (search_sum >= (W+1)'(N)) begin
            search_sum = search_sum - (W+1)'(N);
        end
        search_idx = search_sum[W-1:0];
    end

    // Hint is honoured only when in range and currently excited; otherwise fall back to the search.
    always_comb begin
        hint_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (choice == W'(i) && excited[i]) begin
                hint_hit = 1'b1;
            end
        end
        pick_hit = search_hit;
        pick     = (!det && hint_hit) ? choice : search_idx;
    end

    always_comb begin
        state_d      = state_q;
        fire_d       = fire_q;
        fire_valid_d = fire_valid_q;
        ptr_d        = ptr_q;
        quiet_cnt_d  = quiet_cnt_q;
        quiescent_d  = quiescent_q;
        fire_count_d = fire_count_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            SELECT: begin
                if (pick_hit) begin
                    state_d      = FIRE;
                    fire_d       = pick;
                    fire_valid_d = 1'b1;
                    ptr_d        = (pick == LAST) ? '0 : pick + W'(1);
                    quiet_cnt_d  = '0;
                    quiescent_d  = 1'b0;
                end else begin
                    quiet_cnt_d = (quiet_cnt_q == QLIM) ? QLIM : quiet_cnt_q + QW'(1);
                    quiescent_d = quiescent_q || (quiet_cnt_d == QLIM);
                end
            end
            FIRE: begin
                state_d      = SETTLE;
                fire_d       = IDLE;
                fire_valid_d = 1'b0;
                fire_count_d = (fire_count_q == CNT_MAX) ? CNT_MAX : fire_count_q + CNT_W'(1);
                settle_cnt_d = SETTLE_INIT;
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = SELECT;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            default: begin
                state_d      = SELECT;
                fire_d       = IDLE;
                fire_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SELECT;
            fire_q       <= IDLE;
            fire_valid_q <= 1'b0;
            ptr_q        <= '0;
            quiet_cnt_q  <= '0;
            quiescent_q  <= 1'b0;
            fire_count_q <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            fire_q       <= fire_d;
            fire_valid_q <= fire_valid_d;
            ptr_q        <= ptr_d;
            quiet_cnt_q  <= quiet_cnt_d;
            quiescent_q  <= quiescent_d;
            fire_count_q <= fire_count_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign fire       = fire_q;
    assign fire_valid = fire_valid_q;
    assign quiescent  = quiescent_q;
    assign fire_count = fire_count_q;

endmodule
